// File: rtl/counter_seq_ctrl.sv
// ============================================================================
// Module   : counter_seq_ctrl
// Brief    : Load/run/pause/resume sequencer around a WIDTH-bit up/down counter
//            with terminal-count detection, one-shot or auto-reload.
//            Optional prescaler enabled by defining CNT_CTRL_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  reload_md,
    input  logic                  up_dn,
    input  logic [WIDTH-1:0]      load_val,
`ifdef CNT_CTRL_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  tc,
    output logic                  done,
    output logic [2:0]            state
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_RUN  = 3'd2;
    localparam logic [2:0] c_ST_HOLD = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic             done_q,     done_d;
    logic             reload_q,   reload_d;
    logic             up_q,       up_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;

    logic             w_step;
    logic [WIDTH-1:0] w_terminal;

`ifdef CNT_CTRL_PRESCALE_EN
    localparam logic [PRESCALE_W-1:0] c_PONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    assign w_step = (presc_cnt_q == presc);
`else
    assign w_step = 1'b1;
`endif

    assign w_terminal = up_q ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = 1'b0;
        reload_d   = reload_q;
        up_d       = up_q;
        load_val_d = load_val_q;
`ifdef CNT_CTRL_PRESCALE_EN
        presc_cnt_d = presc_cnt_q;
`endif
        if (clear) begin
            // Abort also drops the latched configuration.
            state_d    = c_ST_IDLE;
            count_d    = '0;
            reload_d   = 1'b0;
            up_d       = 1'b0;
            load_val_d = '0;
`ifdef CNT_CTRL_PRESCALE_EN
            presc_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (start) state_d = c_ST_LOAD;
                end
                c_ST_LOAD: begin
                    count_d    = load_val;
                    reload_d   = reload_md;
                    up_d       = up_dn;
                    load_val_d = load_val;
                    state_d    = c_ST_RUN;
`ifdef CNT_CTRL_PRESCALE_EN
                    presc_cnt_d = '0;
`endif
                end
                c_ST_RUN: begin
                    if (pause) begin
                        state_d = c_ST_HOLD;
                    end else begin
`ifdef CNT_CTRL_PRESCALE_EN
                        presc_cnt_d = w_step ? '0 : presc_cnt_q + c_PONE;
`endif
                        if (w_step) begin
                            if (count_q == w_terminal) begin
                                done_d = 1'b1;
                                if (reload_q) count_d = load_val_q;
                                else          state_d = c_ST_DONE;
                            end else if (up_q) begin
                                count_d = count_q + c_ONE;
                            end else begin
                                count_d = count_q - c_ONE;
                            end
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (!pause) state_d = c_ST_RUN;
                end
                c_ST_DONE: begin
                    if (start) state_d = c_ST_LOAD;
                end
                default: begin
                    state_d = c_ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_IDLE;
            count_q    <= '0;
            done_q     <= 1'b0;
            reload_q   <= 1'b0;
            up_q       <= 1'b0;
            load_val_q <= '0;
`ifdef CNT_CTRL_PRESCALE_EN
            presc_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            reload_q   <= reload_d;
            up_q       <= up_d;
            load_val_q <= load_val_d;
`ifdef CNT_CTRL_PRESCALE_EN
            presc_cnt_q <= presc_cnt_d;
`endif
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == c_ST_LOAD) || (state_q == c_ST_RUN) || (state_q == c_ST_HOLD);
    assign tc    = (state_q == c_ST_RUN) && (count_q == w_terminal);

endmodule

`default_nettype wire
